// File: rtl/pwd_candidate_gen.sv
// ============================================================================
// pwd_candidate_gen
// ----------------------------------------------------------------------------
// Brute-force password enumerator that feeds the NTLM hash stage. It produces
// one candidate per accepted valid/ready handshake, shortest length first.
// Each length is walked as an odometer where the last character turns fastest.
//
// Candidate packing: byte i sits at instr[8*i +: 8]. Byte 0 occupies
// instr[0:7], which is the most-significant byte of the vector. Bytes at
// index >= length are 8'h00.
//
// Build option:
//   PWD_GEN_DIGITS_EN  When defined, the alphabet is 'a'..'z' followed by
//                      '0'..'9' (36 symbols, last symbol '9'). When it is
//                      undefined, the alphabet is 'a'..'z' (26 symbols).
//
// Parameters:
//   MAX_LEN     longest candidate length (1..15)
//   CNT_W       width of the accepted-candidate counter
//
// Ports:
//   clk         system clock, rising edge
//   n_rst       asynchronous active-low reset
//   start       one-cycle pulse; begin enumeration at start_len (IDLE/DONE)
//   start_len   initial length, legal 1..MAX_LEN; other values are ignored
//   abort       stop enumeration and return to IDLE; wins over start
//   ready       downstream accepts the current candidate
//   valid       instr/length hold a valid candidate (state RUN)
//   instr       packed ASCII candidate
//   length      candidate length in characters
//   busy        high in RUN
//   done        high in DONE: the candidate space is exhausted
//   cand_count  handshakes accepted since the last start (saturating)
// ============================================================================
module pwd_candidate_gen #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [3:0]       start_len,
    input  logic             abort,
    input  logic             ready,
    output logic             valid,
    output logic [0:127]     instr,
    output logic [0:3]       length,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cand_count
);

    localparam logic [7:0] FIRST_SYM = 8'h61;          // 'a'
`ifdef PWD_GEN_DIGITS_EN
    localparam logic [7:0] LAST_SYM  = 8'h39;          // '9'
`else
    localparam logic [7:0] LAST_SYM  = 8'h7a;          // 'z'
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       chars_q [MAX_LEN];
    logic [7:0]       chars_d [MAX_LEN];
    logic [3:0]       len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [7:0]       adv [MAX_LEN];     // candidate advanced by one step
    logic             all_last;          // every in-length byte is LAST_SYM
    logic             start_ok;

    // Successor of a non-last symbol. The wrap from LAST_SYM back to 'a' is
    // handled by the carry chain, so it is never asked for here.
    function automatic logic [7:0] next_sym(input logic [7:0] c);
`ifdef PWD_GEN_DIGITS_EN
        if (c == 8'h7a) return 8'h30;    // 'z' -> '0'
        return c + 8'd1;
`else
        return c + 8'd1;
`endif
    endfunction

    // Odometer step. Bytes beyond the current length hold 8'h00 and pass the
    // carry through untouched. A carry out of byte 0 means the length is used up.
    // NOTE: combinational blocks use blocking '=' so the carry ripples in loop
    // order. Registers below take non-blocking '<=' only.
    always_comb begin
        logic carry;
        carry = 1'b1;
        for (int i = MAX_LEN - 1; i >= 0; i--) begin
            adv[i] = chars_q[i];
            if (i < int'(len_q) && carry) begin
                if (chars_q[i] == LAST_SYM) begin
                    adv[i] = FIRST_SYM;
                end else begin
                    adv[i] = next_sym(chars_q[i]);
                    carry  = 1'b0;
                end
            end
        end
        all_last = carry;
    end

    assign start_ok = start && !abort && (start_len != 4'd0) &&
                      (int'(start_len) <= MAX_LEN);

    // Next-state, datapath and output decode.
    // NOTE: every signal driven here gets a default first. A path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        chars_d = chars_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        valid   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (start_ok) begin
                    state_d = RUN;
                    len_d   = start_len;
                    cnt_d   = '0;
                    for (int i = 0; i < MAX_LEN; i++)
                        chars_d[i] = (i < int'(start_len)) ? FIRST_SYM : 8'h00;
                end
            end

            RUN: begin
                // A handshake in the abort cycle is still counted.
                if (ready && (cnt_q != {CNT_W{1'b1}}))
                    cnt_d = cnt_q + CNT_W'(1);

                if (abort) begin
                    state_d = IDLE;
                    len_d   = 4'd0;
                    for (int i = 0; i < MAX_LEN; i++)
                        chars_d[i] = 8'h00;
                end else if (ready) begin
                    if (!all_last) begin
                        chars_d = adv;
                    end else if (int'(len_q) < MAX_LEN) begin
                        // Roll over into the next length, e.g. "zz" -> "aaa".
                        len_d = len_q + 4'd1;
                        for (int i = 0; i < MAX_LEN; i++)
                            chars_d[i] = (i <= int'(len_q)) ? FIRST_SYM : 8'h00;
                    end else begin
                        // Space exhausted; the last candidate stays visible.
                        state_d = DONE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        valid = (state_q == RUN);
        busy  = (state_q == RUN);
        done  = (state_q == DONE);
    end

    // NOTE: the character array is reset together with the other registers.
    // It drives instr directly, and instr must read zero out of reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            len_q   <= 4'd0;
            cnt_q   <= '0;
            for (int i = 0; i < MAX_LEN; i++)
                chars_q[i] <= 8'h00;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            chars_q <= chars_d;
        end
    end

    // Output mapping is wiring only. There is no path from ready to instr or valid.
    always_comb begin
        instr = '0;
        for (int i = 0; i < MAX_LEN; i++)
            instr[8*i +: 8] = chars_q[i];
    end

    assign length     = len_q;
    assign cand_count = cnt_q;

endmodule

// File: tb/tb_pwd_candidate_gen.sv
// ============================================================================
// tb_pwd_candidate_gen
// ----------------------------------------------------------------------------
// Directed bench for pwd_candidate_gen. Three instances share clk/n_rst:
//   u_dut    MAX_LEN=8, CNT_W=32 : table vectors, stall, abort, illegal start
//   u_small  MAX_LEN=2, CNT_W=32 : full enumeration "a".."zz" to DONE
//   u_sat    MAX_LEN=2, CNT_W=4  : same stimulus as u_small, counter saturation
// ============================================================================
module tb_pwd_candidate_gen;

`ifdef PWD_GEN_DIGITS_EN
    localparam int ALPHA = 36;
`else
    localparam int ALPHA = 26;
`endif

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    // u_dut
    logic         start, abort, ready;
    logic [3:0]   start_len;
    logic         valid, busy, done;
    logic [0:127] instr;
    logic [0:3]   length;
    logic [31:0]  cand_count;

    // u_small / u_sat
    logic         s_start, s_abort, s_ready;
    logic [3:0]   s_start_len;
    logic         s_valid, s_busy, s_done;
    logic [0:127] s_instr;
    logic [0:3]   s_length;
    logic [31:0]  s_cand_count;
    logic         t_valid, t_busy, t_done;
    logic [0:127] t_instr;
    logic [0:3]   t_length;
    logic [3:0]   t_cand_count;

    pwd_candidate_gen #(.MAX_LEN(8), .CNT_W(32)) u_dut (
        .clk(clk), .n_rst(n_rst), .start(start), .start_len(start_len),
        .abort(abort), .ready(ready), .valid(valid), .instr(instr),
        .length(length), .busy(busy), .done(done), .cand_count(cand_count)
    );

    pwd_candidate_gen #(.MAX_LEN(2), .CNT_W(32)) u_small (
        .clk(clk), .n_rst(n_rst), .start(s_start), .start_len(s_start_len),
        .abort(s_abort), .ready(s_ready), .valid(s_valid), .instr(s_instr),
        .length(s_length), .busy(s_busy), .done(s_done), .cand_count(s_cand_count)
    );

    pwd_candidate_gen #(.MAX_LEN(2), .CNT_W(4)) u_sat (
        .clk(clk), .n_rst(n_rst), .start(s_start), .start_len(s_start_len),
        .abort(s_abort), .ready(s_ready), .valid(t_valid), .instr(t_instr),
        .length(t_length), .busy(t_busy), .done(t_done), .cand_count(t_cand_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Right-justified ASCII literal of n characters -> instr packing.
    function automatic logic [0:127] pack_str(input logic [63:0] s, input int n);
        logic [0:127] r;
        r = '0;
        for (int k = 0; k < n; k++)
            r[8*k +: 8] = s[8*(n-1-k) +: 8];
        return r;
    endfunction

    // Independent reference for the MAX_LEN=2 walk: k-th candidate from "a".
    function automatic logic [7:0] sym(input int idx);
        if (idx < 26) return 8'(8'h61 + idx);
        return 8'(8'h30 + idx - 26);
    endfunction

    function automatic logic [0:127] small_instr(input int k);
        logic [0:127] r;
        r = '0;
        if (k < ALPHA) begin
            r[0:7] = sym(k);
        end else begin
            r[0:7]  = sym((k - ALPHA) / ALPHA);
            r[8:15] = sym((k - ALPHA) % ALPHA);
        end
        return r;
    endfunction

    typedef struct packed {
        logic [3:0]  start_len;
        logic [31:0] n_acc;
        logic [3:0]  exp_len;
        logic [63:0] exp_str;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    initial begin
        n_rst = 1'b0;
        start = 1'b0; abort = 1'b0; ready = 1'b0; start_len = 4'd0;
        s_start = 1'b0; s_abort = 1'b0; s_ready = 1'b0; s_start_len = 4'd0;

        // Vector table: start length, accepted handshakes, expected candidate.
        vecs[0] = '{4'd1, 32'd0,   4'd1, 64'("a")};
        vecs[1] = '{4'd1, 32'd25,  4'd1, 64'("z")};
`ifdef PWD_GEN_DIGITS_EN
        vecs[2] = '{4'd1, 32'd26,  4'd1, 64'("0")};
        vecs[3] = '{4'd1, 32'd35,  4'd1, 64'("9")};
        vecs[4] = '{4'd2, 32'd26,  4'd2, 64'("a0")};
        vecs[5] = '{4'd2, 32'd27,  4'd2, 64'("a1")};
        vecs[6] = '{4'd2, 32'd675, 4'd2, 64'("s1")};
        vecs[9] = '{4'd2, 32'd676, 4'd2, 64'("s2")};
`else
        vecs[2] = '{4'd1, 32'd26,  4'd2, 64'("aa")};
        vecs[3] = '{4'd1, 32'd35,  4'd2, 64'("aj")};
        vecs[4] = '{4'd2, 32'd26,  4'd2, 64'("ba")};
        vecs[5] = '{4'd2, 32'd27,  4'd2, 64'("bb")};
        vecs[6] = '{4'd2, 32'd675, 4'd2, 64'("zz")};
        vecs[9] = '{4'd2, 32'd676, 4'd3, 64'("aaa")};
`endif
        vecs[7] = '{4'd3, 32'd1,   4'd3, 64'("aab")};
        vecs[8] = '{4'd8, 32'd0,   4'd8, 64'("aaaaaaaa")};

        // ---- Reset held while inputs toggle ----
        for (int i = 0; i < 4; i++) begin
            start = ~start; ready = ~ready; start_len = 4'd2; abort = i[0];
            tick();
        end
        check("rst_valid", 128'(valid), 128'(1'b0));
        check("rst_busy",  128'(busy),  128'(1'b0));
        check("rst_done",  128'(done),  128'(1'b0));
        check("rst_instr", instr,       128'h0);
        check("rst_len",   128'(length), 128'(4'd0));
        check("rst_cnt",   128'(cand_count), 128'(32'd0));
        start = 1'b0; ready = 1'b0; abort = 1'b0;
        n_rst = 1'b1;
        tick();

        // ---- Illegal start lengths and start+abort are ignored ----
        start = 1'b1; start_len = 4'd0; tick(); start = 1'b0; tick();
        check("len0_valid", 128'(valid), 128'(1'b0));
        check("len0_busy",  128'(busy),  128'(1'b0));
        start = 1'b1; start_len = 4'd9; tick(); start = 1'b0; tick();
        check("len9_valid", 128'(valid), 128'(1'b0));
        check("len9_instr", instr, 128'h0);
        start = 1'b1; start_len = 4'd2; abort = 1'b1; tick();
        start = 1'b0; abort = 1'b0; tick();
        check("start_abort_valid", 128'(valid), 128'(1'b0));

        // ---- Table vectors ----
        for (int v = 0; v < NVEC; v++) begin
            abort = 1'b1; tick(); abort = 1'b0;
            start = 1'b1; start_len = vecs[v].start_len; tick(); start = 1'b0;
            ready = 1'b1;
            repeat (int'(vecs[v].n_acc)) tick();
            ready = 1'b0;
            check($sformatf("vec%0d_valid", v), 128'(valid), 128'(1'b1));
            check($sformatf("vec%0d_instr", v), instr,
                  pack_str(vecs[v].exp_str, int'(vecs[v].exp_len)));
            check($sformatf("vec%0d_len", v), 128'(length), 128'(vecs[v].exp_len));
            check($sformatf("vec%0d_cnt", v), 128'(cand_count), 128'(vecs[v].n_acc));
        end

        // ---- Stall: ready low holds the candidate; start in RUN ignored ----
        abort = 1'b1; tick(); abort = 1'b0;
        start = 1'b1; start_len = 4'd3; tick(); start = 1'b0;
        repeat (5) tick();
        check("stall_instr", instr, 128'h61616100000000000000000000000000);
        check("stall_len",   128'(length), 128'(4'd3));
        check("stall_cnt",   128'(cand_count), 128'(32'd0));
        start = 1'b1; start_len = 4'd5; tick(); start = 1'b0;
        check("run_start_len", 128'(length), 128'(4'd3));
        ready = 1'b1; tick(); ready = 1'b0; tick();
        check("stall_next", instr, 128'h61616200000000000000000000000000);
        check("stall_cnt1", 128'(cand_count), 128'(32'd1));

        // ---- Abort after 10 accepts, then restart ----
        abort = 1'b1; tick(); abort = 1'b0;
        start = 1'b1; start_len = 4'd2; tick(); start = 1'b0;
        ready = 1'b1; repeat (10) tick(); ready = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_valid", 128'(valid), 128'(1'b0));
        check("abort_busy",  128'(busy),  128'(1'b0));
        check("abort_done",  128'(done),  128'(1'b0));
        check("abort_cnt",   128'(cand_count), 128'(32'd10));
        check("abort_instr", instr, 128'h0);
        tick();
        check("abort_cnt_hold", 128'(cand_count), 128'(32'd10));
        start = 1'b1; start_len = 4'd1; tick(); start = 1'b0;
        check("restart_instr", instr, pack_str(64'("a"), 1));
        check("restart_cnt",   128'(cand_count), 128'(32'd0));

        // ---- Handshake in the abort cycle is counted ----
        ready = 1'b1; repeat (3) tick();
        abort = 1'b1; tick(); abort = 1'b0; ready = 1'b0;
        check("abort_hs_cnt",   128'(cand_count), 128'(32'd4));
        check("abort_hs_valid", 128'(valid), 128'(1'b0));

        // ---- Full enumeration on MAX_LEN=2 ----
        begin
            int k = 0;
            int bad = 0;
            int guard = 0;
            s_start = 1'b1; s_start_len = 4'd1; tick(); s_start = 1'b0;
            s_ready = 1'b1;
            while (s_valid && guard < 5000) begin
                if ((s_instr !== small_instr(k)) ||
                    (s_length !== ((k < ALPHA) ? 4'd1 : 4'd2))) begin
                    if (bad == 0)
                        $display("FAIL seq_item%0d: got %h/%0d expected %h",
                                 k, s_instr, s_length, small_instr(k));
                    bad++;
                end
                tick();
                k++;
                guard++;
            end
            s_ready = 1'b0;
            check("seq_bad_items", 128'(bad), 128'(0));
            check("seq_total",     128'(k),   128'(ALPHA + ALPHA * ALPHA));
        end
        check("full_done",  128'(s_done),  128'(1'b1));
        check("full_busy",  128'(s_busy),  128'(1'b0));
        check("full_valid", 128'(s_valid), 128'(1'b0));
        check("full_cnt",   128'(s_cand_count), 128'(ALPHA + ALPHA * ALPHA));
`ifdef PWD_GEN_DIGITS_EN
        check("full_last",  s_instr, pack_str(64'("99"), 2));
`else
        check("full_last",  s_instr, pack_str(64'("zz"), 2));
`endif
        check("full_len",   128'(s_length), 128'(4'd2));
        check("sat_cnt",    128'(t_cand_count), 128'(4'hf));
        check("sat_done",   128'(t_done), 128'(1'b1));
        s_abort = 1'b1; tick(); s_abort = 1'b0;
        check("done_abort_done", 128'(s_done), 128'(1'b0));

        // ---- Asynchronous reset mid-RUN ----
        start = 1'b1; start_len = 4'd2; tick(); start = 1'b0;
        ready = 1'b1; repeat (3) tick();
        #2 n_rst = 1'b0;
        #1;
        check("arst_valid", 128'(valid), 128'(1'b0));
        check("arst_busy",  128'(busy),  128'(1'b0));
        check("arst_instr", instr, 128'h0);
        check("arst_len",   128'(length), 128'(4'd0));
        check("arst_cnt",   128'(cand_count), 128'(32'd0));
        ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
